// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: FSM states and requester ids.
package mem_arbiter_pkg;

    typedef enum logic {IDLE, ACCESS} state_t;
    typedef enum logic {REQ_CPU, REQ_DBG} req_id_t;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin winner selection; purely combinational.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic    req_cpu,
    input  logic    req_dbg,
    input  req_id_t last,
    output req_id_t gnt,
    output logic    valid
);

    always_comb begin
        valid = req_cpu | req_dbg;
        gnt   = REQ_CPU;
        if (req_cpu && req_dbg) begin
            gnt = (last == REQ_CPU) ? REQ_DBG : REQ_CPU;
        end else if (req_dbg) begin
            gnt = REQ_DBG;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and debug/loader access to one single-port memory with
// a fixed number of wait states per access.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_adr,
    input  logic [31:0] cpu_wd,
    output logic        cpu_rdy,
    output logic [31:0] cpu_rd,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_adr,
    input  logic [31:0] dbg_wd,
    output logic        dbg_rdy,
    output logic [31:0] dbg_rd,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    req_id_t          id;
    req_id_t          last;
    logic             we_l;

    req_id_t          gnt;
    logic             gnt_valid;
    logic             sel_we;
    logic [31:0]      sel_adr;
    logic [31:0]      sel_wd;

    rr_arb2 u_rr_arb2 (
        .req_cpu (cpu_req),
        .req_dbg (dbg_req),
        .last    (last),
        .gnt     (gnt),
        .valid   (gnt_valid)
    );

    always_comb begin
        sel_we  = cpu_we;
        sel_adr = cpu_adr;
        sel_wd  = cpu_wd;
        if (gnt == REQ_DBG) begin
            sel_we  = dbg_we;
            sel_adr = dbg_adr;
            sel_wd  = dbg_wd;
        end
    end

    // Read data is combinational from memory and only meaningful in the rdy cycle.
    assign cpu_rd = mem_rd;
    assign dbg_rd = mem_rd;

    // Strobes are registered on the edge that enters the final ACCESS cycle
    // (counter reaching zero), so they are high exactly while cnt == 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            id      <= REQ_CPU;
            last    <= REQ_DBG;
            we_l    <= 1'b0;
            mem_a   <= '0;
            mem_wd  <= '0;
            mem_we  <= 1'b0;
            cpu_rdy <= 1'b0;
            dbg_rdy <= 1'b0;
        end else begin
            mem_we  <= 1'b0;
            cpu_rdy <= 1'b0;
            dbg_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        id     <= gnt;
                        last   <= gnt;
                        we_l   <= sel_we;
                        mem_a  <= sel_adr;
                        mem_wd <= sel_wd;
                        cnt    <= WAIT_CNT;
                        state  <= ACCESS;
                        if (WAIT_CNT == '0) begin
                            mem_we  <= sel_we;
                            cpu_rdy <= (gnt == REQ_CPU);
                            dbg_rdy <= (gnt == REQ_DBG);
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            mem_we  <= we_l;
                            cpu_rdy <= (id == REQ_CPU);
                            dbg_rdy <= (id == REQ_DBG);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: three arbiters (WAIT = 0, 1, 3) each on its own memory model.
module tb_mem_arbiter;

    localparam int WAITS [3] = '{0, 1, 3};

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_load;
    logic [2:0]  cpu_req, cpu_we, cpu_rdy, dbg_req, dbg_we, dbg_rdy, mem_we;
    logic [31:0] cpu_adr [3];
    logic [31:0] cpu_wd  [3];
    logic [31:0] cpu_rd  [3];
    logic [31:0] dbg_adr [3];
    logic [31:0] dbg_wd  [3];
    logic [31:0] dbg_rd  [3];
    logic [31:0] mem_a   [3];
    logic [31:0] mem_wd  [3];
    logic [31:0] mem_rd  [3];

    logic [31:0] mem     [3][64];
    logic [31:0] ref_mem [3][64];
    int          we_cnt  [3] = '{0, 0, 0};
    int          viol    = 0;
    int          last_m  [3];
    int          checks  = 0;
    int          errors  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return {16'h2000 + 16'(i), 16'h0003 + 16'(i)};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_arbiter #(.WAIT(WAITS[g])) u_dut (
            .clk     (clk),
            .reset   (reset),
            .cpu_req (cpu_req[g]),
            .cpu_we  (cpu_we[g]),
            .cpu_adr (cpu_adr[g]),
            .cpu_wd  (cpu_wd[g]),
            .cpu_rdy (cpu_rdy[g]),
            .cpu_rd  (cpu_rd[g]),
            .dbg_req (dbg_req[g]),
            .dbg_we  (dbg_we[g]),
            .dbg_adr (dbg_adr[g]),
            .dbg_wd  (dbg_wd[g]),
            .dbg_rdy (dbg_rdy[g]),
            .dbg_rd  (dbg_rd[g]),
            .mem_we  (mem_we[g]),
            .mem_a   (mem_a[g]),
            .mem_wd  (mem_wd[g]),
            .mem_rd  (mem_rd[g])
        );
        assign mem_rd[g] = mem[g][mem_a[g][7:2]];
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mem_load) begin
                for (int i = 0; i < 64; i++) mem[k][i] <= init_word(i);
            end else if (mem_we[k]) begin
                mem[k][mem_a[k][7:2]] <= mem_wd[k];
                we_cnt[k] <= we_cnt[k] + 1;
            end
        end
    end

    // Protocol watch: never two rdys at once, never a write strobe without a rdy.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (cpu_rdy[k] && dbg_rdy[k]) viol <= viol + 1;
            if (mem_we[k] && !(cpu_rdy[k] || dbg_rdy[k])) viol <= viol + 1;
        end
    end

    task automatic wait_any(input int k, output int who, output int n);
        who = -1;
        n   = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (cpu_rdy[k] || dbg_rdy[k]) begin
                n   = c;
                who = cpu_rdy[k] ? 0 : 1;
                return;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) last_m[k] = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({cpu_rdy[k], dbg_rdy[k], mem_we[k]} !== 3'b000) begin
                errors++;
                $display("FAIL reset_strobes k=%0d: got %b, expected 000", k, {cpu_rdy[k], dbg_rdy[k], mem_we[k]});
            end
            checks++;
            if ((mem_a[k] | mem_wd[k]) !== 32'h0) begin
                errors++;
                $display("FAIL reset_bus k=%0d: got a=%h wd=%h, expected 0", k, mem_a[k], mem_wd[k]);
            end
        end
        mem_load = 1'b0;
        reset    = 1'b0;
        for (int k = 0; k < 3; k++) last_m[k] = 1;
    endtask

    task automatic test_read_latency();
        int who, n, idx;
        for (int k = 0; k < 3; k++) begin
            idx = (k == 1) ? 2 : int'($urandom_range(0, 63));
            cpu_adr[k] = 32'(idx) << 2;
            cpu_we[k]  = 1'b0;
            cpu_req[k] = 1'b1;
            wait_any(k, who, n);
            checks++;
            if (who !== 0 || n !== WAITS[k] + 1) begin
                errors++;
                $display("FAIL read_latency k=%0d: got who=%0d n=%0d, expected who=0 n=%0d", k, who, n, WAITS[k] + 1);
            end
            checks++;
            if (cpu_rd[k] !== ref_mem[k][idx] || (k == 1 && cpu_rd[k] !== 32'h20020005)) begin
                errors++;
                $display("FAIL read_data k=%0d: got %h, expected %h", k, cpu_rd[k], ref_mem[k][idx]);
            end
            cpu_req[k] = 1'b0;
            last_m[k]  = 0;
            @(negedge clk);
        end
    endtask

    task automatic test_write_read();
        int who, n, base;
        base = we_cnt[0];
        dbg_adr[0] = 32'h10;
        dbg_wd[0]  = 32'hDEADBEEF;
        dbg_we[0]  = 1'b1;
        dbg_req[0] = 1'b1;
        wait_any(0, who, n);
        checks++;
        if (who !== 1 || n !== 1) begin
            errors++;
            $display("FAIL dbg_write k=0: got who=%0d n=%0d, expected who=1 n=1", who, n);
        end
        dbg_req[0] = 1'b0;
        dbg_we[0]  = 1'b0;
        last_m[0]  = 1;
        ref_mem[0][4] = 32'hDEADBEEF;
        @(negedge clk);
        cpu_adr[0] = 32'h10;
        cpu_we[0]  = 1'b0;
        cpu_req[0] = 1'b1;
        wait_any(0, who, n);
        checks++;
        if (who !== 0 || cpu_rd[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_after_write k=0: got who=%0d rd=%h, expected who=0 rd=deadbeef", who, cpu_rd[0]);
        end
        cpu_req[0] = 1'b0;
        last_m[0]  = 0;
        @(negedge clk);
        checks++;
        if (we_cnt[0] - base !== 1) begin
            errors++;
            $display("FAIL write_pulses k=0: got %0d, expected 1", we_cnt[0] - base);
        end
    endtask

    task automatic test_round_robin();
        int who, n, exp_who, exp_n;
        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            cpu_adr[k] = 32'h20;
            dbg_adr[k] = 32'h24;
            cpu_we[k]  = 1'b0;
            dbg_we[k]  = 1'b0;
            cpu_req[k] = 1'b1;
            dbg_req[k] = 1'b1;
            exp_who    = (last_m[k] == 0) ? 1 : 0;
            for (int i = 0; i < 4; i++) begin
                exp_n = WAITS[k] + ((i == 0) ? 1 : 2);
                wait_any(k, who, n);
                checks++;
                if (who !== exp_who || n !== exp_n) begin
                    errors++;
                    $display("FAIL rr_order k=%0d i=%0d: got who=%0d n=%0d, expected who=%0d n=%0d", k, i, who, n, exp_who, exp_n);
                end
                checks++;
                if ((exp_who == 0 ? cpu_rd[k] : dbg_rd[k]) !== ref_mem[k][exp_who == 0 ? 8 : 9]) begin
                    errors++;
                    $display("FAIL rr_data k=%0d i=%0d: got %h, expected %h", k, i, exp_who == 0 ? cpu_rd[k] : dbg_rd[k], ref_mem[k][exp_who == 0 ? 8 : 9]);
                end
                last_m[k] = exp_who;
                exp_who   = 1 - exp_who;
            end
            cpu_req[k] = 1'b0;
            dbg_req[k] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_addr_change();
        int who, n, base;
        base = we_cnt[2];
        cpu_adr[2] = 32'h4;
        cpu_we[2]  = 1'b0;
        cpu_req[2] = 1'b1;
        @(negedge clk);
        cpu_adr[2] = 32'hC;
        cpu_we[2]  = 1'b1;
        cpu_wd[2]  = $urandom;
        wait_any(2, who, n);
        checks++;
        if (who !== 0 || n + 1 !== WAITS[2] + 1 || mem_a[2] !== 32'h4) begin
            errors++;
            $display("FAIL addr_change k=2: got who=%0d n=%0d a=%h, expected who=0 n=%0d a=4", who, n + 1, mem_a[2], WAITS[2] + 1);
        end
        checks++;
        if (cpu_rd[2] !== ref_mem[2][1]) begin
            errors++;
            $display("FAIL addr_change_data k=2: got %h, expected %h", cpu_rd[2], ref_mem[2][1]);
        end
        cpu_req[2] = 1'b0;
        cpu_we[2]  = 1'b0;
        last_m[2]  = 0;
        @(negedge clk);
        checks++;
        if (we_cnt[2] !== base) begin
            errors++;
            $display("FAIL addr_change_nowrite k=2: got %0d writes, expected 0", we_cnt[2] - base);
        end
    endtask

    task automatic test_reset_abort();
        int who, n, base;
        base = we_cnt[2];
        cpu_adr[2] = 32'h30;
        cpu_wd[2]  = $urandom;
        cpu_we[2]  = 1'b1;
        cpu_req[2] = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({cpu_rdy[2], dbg_rdy[2], mem_we[2]} !== 3'b000 || mem_a[2] !== 32'h0) begin
            errors++;
            $display("FAIL abort_async k=2: got strobes=%b a=%h, expected 000 and 0", {cpu_rdy[2], dbg_rdy[2], mem_we[2]}, mem_a[2]);
        end
        @(negedge clk);
        cpu_req[2] = 1'b0;
        cpu_we[2]  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) last_m[k] = 1;
        checks++;
        if (we_cnt[2] !== base) begin
            errors++;
            $display("FAIL abort_nowrite k=2: got %0d writes, expected 0", we_cnt[2] - base);
        end
        cpu_adr[2] = 32'h30;
        dbg_adr[2] = 32'h34;
        dbg_we[2]  = 1'b0;
        cpu_req[2] = 1'b1;
        dbg_req[2] = 1'b1;
        wait_any(2, who, n);
        checks++;
        if (who !== 0 || n !== WAITS[2] + 1 || cpu_rd[2] !== ref_mem[2][12]) begin
            errors++;
            $display("FAIL abort_tie k=2: got who=%0d n=%0d rd=%h, expected who=0 n=%0d rd=%h", who, n, cpu_rd[2], WAITS[2] + 1, ref_mem[2][12]);
        end
        cpu_req[2] = 1'b0;
        wait_any(2, who, n);
        checks++;
        if (who !== 1 || n !== WAITS[2] + 2) begin
            errors++;
            $display("FAIL abort_loser k=2: got who=%0d n=%0d, expected who=1 n=%0d", who, n, WAITS[2] + 2);
        end
        dbg_req[2] = 1'b0;
        last_m[2]  = 1;
        @(negedge clk);
    endtask

    task automatic test_random();
        int who, n, mode, base, nwr, exp_who, exp_n, idx;
        int r_we [2];
        int r_idx [2];
        logic [31:0] r_wd [2];
        int order [$];
        logic [31:0] got;
        for (int k = 0; k < 3; k++) begin
            for (int it = 0; it < 15; it++) begin
                mode = int'($urandom_range(0, 2));
                base = we_cnt[k];
                nwr  = 0;
                for (int r = 0; r < 2; r++) begin
                    r_we[r]  = int'($urandom_range(0, 1));
                    r_idx[r] = int'($urandom_range(0, 63));
                    r_wd[r]  = $urandom;
                end
                cpu_we[k]  = r_we[0][0];  cpu_adr[k] = 32'(r_idx[0]) << 2;  cpu_wd[k] = r_wd[0];
                dbg_we[k]  = r_we[1][0];  dbg_adr[k] = 32'(r_idx[1]) << 2;  dbg_wd[k] = r_wd[1];
                cpu_req[k] = (mode != 1);
                dbg_req[k] = (mode != 0);
                order.delete();
                if (mode == 2) begin
                    order.push_back(last_m[k] == 0 ? 1 : 0);
                    order.push_back(last_m[k] == 0 ? 0 : 1);
                end else begin
                    order.push_back(mode);
                end
                foreach (order[j]) begin
                    exp_who = order[j];
                    exp_n   = WAITS[k] + ((j == 0) ? 1 : 2);
                    idx     = r_idx[exp_who];
                    wait_any(k, who, n);
                    got = (exp_who == 0) ? cpu_rd[k] : dbg_rd[k];
                    checks++;
                    if (who !== exp_who || n !== exp_n || mem_a[k] !== 32'(idx) << 2) begin
                        errors++;
                        $display("FAIL rand_grant k=%0d it=%0d: got who=%0d n=%0d a=%h, expected who=%0d n=%0d a=%h", k, it, who, n, mem_a[k], exp_who, exp_n, 32'(idx) << 2);
                    end
                    if (r_we[exp_who] == 0) begin
                        checks++;
                        if (got !== ref_mem[k][idx]) begin
                            errors++;
                            $display("FAIL rand_read k=%0d it=%0d: got %h, expected %h", k, it, got, ref_mem[k][idx]);
                        end
                    end else begin
                        ref_mem[k][idx] = r_wd[exp_who];
                        nwr++;
                    end
                    last_m[k] = exp_who;
                    if (exp_who == 0) cpu_req[k] = 1'b0;
                    else              dbg_req[k] = 1'b0;
                end
                @(negedge clk);
                checks++;
                if (we_cnt[k] - base !== nwr) begin
                    errors++;
                    $display("FAIL rand_writes k=%0d it=%0d: got %0d, expected %0d", k, it, we_cnt[k] - base, nwr);
                end
            end
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL protocol: got %0d violations, expected 0", viol);
        end
    endtask

    initial begin
        reset    = 1'b1;
        mem_load = 1'b1;
        cpu_req  = '0;  cpu_we = '0;  dbg_req = '0;  dbg_we = '0;
        for (int k = 0; k < 3; k++) begin
            cpu_adr[k] = '0;  cpu_wd[k] = '0;  dbg_adr[k] = '0;  dbg_wd[k] = '0;
            for (int i = 0; i < 64; i++) ref_mem[k][i] = init_word(i);
        end
        @(negedge clk);
        test_reset();
        @(negedge clk);
        test_read_latency();
        test_write_read();
        test_round_robin();
        test_addr_change();
        test_reset_abort();
        test_random();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
